imm_gen_stage: RTL

- Registered, flow-controlled immediate-generation stage for the decode pipeline, parametrised for RV32/RV64 via XLEN.
- Decodes the immediate for every base-ISA format, including CSR zimm and XLEN-dependent shift amounts.
- Flags illegal shift encodings and forwards instruction and PC with a valid/ready handshake.
- Uses a two-entry skid buffer so the upstream fetch stage never sees a combinational ready path.

---
 rtl/imm_gen_stage.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decodes the base-ISA immediate of the
// entering instruction and forwards it with a two-entry (output + skid) buffer.
module imm_gen_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic [2:0]        out_fmt,
    output logic              out_illegal
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ZIMM  = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic            shamt_bad;
    fmt_e            dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;

    logic              skid_valid;
    logic [31:0]       skid_instr;
    logic [PC_W-1:0]   skid_pc;
    logic [XLEN-1:0]   skid_imm;
    logic [2:0]        skid_fmt;
    logic              skid_ill;

    logic accept;
    logic out_free;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    // Only SRLI/SRAI-style high bits are legal, and SLLI may not carry the arithmetic bit.
    assign shamt_bad = ((in_instr[31:26] != 6'b000000) && (in_instr[31:26] != 6'b010000))
                     || ((funct3 == 3'b001) && in_instr[30]);

    always_comb begin
        dec_fmt = FMT_NONE;
        dec_imm = '0;
        dec_ill = 1'b0;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                dec_fmt = FMT_I;
                dec_imm = XLEN'($signed(in_instr[31:20]));
            end
            OP_STORE: begin
                dec_fmt = FMT_S;
                dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            end
            OP_BRANCH: begin
                dec_fmt = FMT_B;
                dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                         in_instr[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt = FMT_U;
                dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                dec_fmt = FMT_J;
                dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                         in_instr[30:21], 1'b0}));
            end
            OP_IMM: begin
                if (is_shift) begin
                    dec_fmt = FMT_SHAMT;
                    if (XLEN == 32) begin
                        dec_imm = XLEN'(in_instr[24:20]);
                        dec_ill = shamt_bad | in_instr[25];
                    end else begin
                        dec_imm = XLEN'(in_instr[25:20]);
                        dec_ill = shamt_bad;
                    end
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = XLEN'($signed(in_instr[31:20]));
                end
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    if (is_shift) begin
                        dec_fmt = FMT_SHAMT;
                        dec_imm = XLEN'(in_instr[24:20]);
                        dec_ill = shamt_bad | in_instr[25];
                    end else begin
                        dec_fmt = FMT_I;
                        dec_imm = XLEN'($signed(in_instr[31:20]));
                    end
                end
            end
            OP_SYSTEM: begin
                if (funct3[2]) begin
                    dec_fmt = FMT_ZIMM;
                    dec_imm = XLEN'(in_instr[19:15]);
                end
            end
            default: ;
        endcase
    end

    assign accept   = in_valid & in_ready;
    assign out_free = ~out_valid | out_ready;

    // in_ready mirrors skid-empty, so the skid can never be full when a new entry arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            out_imm     <= '0;
            out_fmt     <= '0;
            out_illegal <= 1'b0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            skid_imm    <= '0;
            skid_fmt    <= '0;
            skid_ill    <= 1'b0;
            in_ready    <= 1'b1;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid   <= 1'b1;
                out_instr   <= skid_instr;
                out_pc      <= skid_pc;
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_ill;
                skid_valid  <= 1'b0;
                in_ready    <= 1'b1;
            end else if (accept) begin
                out_valid   <= 1'b1;
                out_instr   <= in_instr;
                out_pc      <= in_pc;
                out_imm     <= dec_imm;
                out_fmt     <= dec_fmt;
                out_illegal <= dec_ill;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_ill   <= dec_ill;
            in_ready   <= 1'b0;
        end
    end

endmodule
